mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-port instruction/data memory between the fetch stage and the execute (load/store) stage of the 2-stage 8-bit processor. Arbitrates requests with data priority and a fetch anti-starvation guard. Sequences each read through the fixed memory latency and returns the data to the owning requester. Drives the pipeline stall signal while a requester waits.

Parameters:
ADDR_W, 8, address width (matches 8-bit PC)
DATA_W, 8, data width (matches 8-bit result path)
MEM_LAT, 1, memory read latency in cycles (legal 1..7)
MAX_DATA_RUN, 4, max consecutive data grants while fetch waits (legal 1..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch read request; held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  one-cycle pulse, if_rdata valid
if_rdata  out  DATA_W  fetched instruction byte
dm_req  in  1  data request; held until dm_gnt
dm_we  in  1  1=write, 0=read
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  write data
dm_gnt  out  1  data request accepted this cycle
dm_rvalid  out  1  one-cycle pulse, dm_rdata valid (reads only)
dm_rdata  out  DATA_W  load data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  valid MEM_LAT cycles after the mem_en read cycle
stall  out  1  (if_req & ~if_gnt) | (dm_req & ~dm_gnt)

Behaviour:
- Clock clk; reset is asynchronous, active-high. Reset sets state IDLE, read counter 0, owner 0, data_run 0, if_rvalid/dm_rvalid 0, if_rdata/dm_rdata 0. Grants and mem_* outputs are combinational from state and inputs, so they are 0 with mem_addr/mem_wdata 0 while reset is high.
- States: IDLE, RD_WAIT.
- IDLE: grants are issued only in this state, at most one per cycle.
  - Choice: if dm_req & if_req & data_run==MAX_DATA_RUN, fetch wins. Otherwise, if dm_req, data wins. Otherwise, if if_req, fetch wins.
  - On the grant cycle, the winner's gnt is 1, mem_en=1, and mem_addr/mem_wdata/mem_we come from the winner. mem_we=0 for fetch.
  - Data write: completes in the grant cycle. State stays IDLE, so back-to-back writes are possible every cycle. No dm_rvalid.
  - Read (fetch or data): latch owner, load counter=MEM_LAT, go to RD_WAIT.
- RD_WAIT: no grants; mem_en=0. Counter decrements each cycle.
  - In the cycle where the counter reaches 1, mem_rdata is valid. Register it into the owner's rdata, pulse the owner's rvalid in the next cycle, and return to IDLE.
  - Read response: rvalid rises MEM_LAT+1 cycles after the grant cycle.
  - A new grant may issue in the same cycle as that rvalid, giving a read throughput of one per MEM_LAT+1 cycles.
- rdata registers hold their last value between pulses.
- data_run:
  - On a data grant with if_req=1: increments, saturating at MAX_DATA_RUN.
  - On a fetch grant: clears to 0.
  - In any IDLE cycle with if_req=0: clears to 0.
- Requesters must hold req/addr/we/wdata stable until gnt. Dropping req before gnt is a protocol violation and its outcome is undefined.
- Reset mid-read: the outstanding read is discarded and no rvalid is issued after reset releases.
- stall is purely combinational. It is 1 during RD_WAIT whenever any req is high.

Test Plan:
- MEM_LAT=1, if_req only, if_addr=0x10, mem_rdata returns 0xA5 -> if_gnt in cycle 0, mem_en=1/mem_we=0/mem_addr=0x10, if_rvalid=1 with if_rdata=0xA5 in cycle 2, stall=0 in cycle 0.
- if_req and dm_req (read, addr 0x40) asserted together, data_run=0 -> dm_gnt first with stall=1. if_gnt is issued on the cycle dm_rvalid pulses.
- MAX_DATA_RUN=4, if_req held, dm_req issues continuous writes -> dm_gnt on 4 consecutive cycles, then if_gnt on cycle 5, then data_run=0.
- Writes to 0x01,0x02,0x03 on consecutive cycles, no fetch -> three consecutive dm_gnt cycles, mem_we=1, and dm_rvalid never asserts.
- MEM_LAT=3, fetch read granted, reset pulsed 1 cycle after grant -> if_rvalid stays 0 and all outputs are 0 during reset. A fresh request after reset is served normally.
- MEM_LAT=3, back-to-back fetch reads -> grants 4 cycles apart, each if_rvalid 4 cycles after its grant, and the second grant coincides with the first rvalid.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and load/store. Data has priority; a run counter guarantees fetch progress.
// Reads are sequenced through the fixed memory latency and returned to the
// requester that issued them; writes complete in their grant cycle.
module mem_port_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int MEM_LAT      = 1,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    localparam logic [2:0] LP_LAT     = 3'(MEM_LAT);
    localparam logic [3:0] LP_MAX_RUN = 4'(MAX_DATA_RUN);
    localparam logic       OWN_IF     = 1'b0;
    localparam logic       OWN_DM     = 1'b1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_cnt;
    logic                r_owner;
    logic [3:0]          r_data_run;
    logic                r_if_rvalid;
    logic                r_dm_rvalid;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_dm_rdata;

    logic                w_idle;
    logic                w_fetch_prio;
    logic                w_gnt_if;
    logic                w_gnt_dm;
    logic                w_rd_gnt;
    logic                w_last;

    // Arbitration: grants only in IDLE and never while reset is asserted
    assign w_idle       = (r_state == IDLE) && !reset;
    assign w_fetch_prio = if_req && dm_req && (r_data_run == LP_MAX_RUN);
    assign w_gnt_dm     = w_idle && dm_req && !w_fetch_prio;
    assign w_gnt_if     = w_idle && if_req && !w_gnt_dm;
    assign w_rd_gnt     = w_gnt_if || (w_gnt_dm && !dm_we);
    assign w_last       = (r_cnt == 3'd1);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state: enter RD_WAIT on a read grant, leave when the data arrives
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_rd_gnt) w_state_nxt = RD_WAIT;
            RD_WAIT: if (w_last)   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs: grants and memory strobes driven from the winning requester
    always_comb begin
        if_gnt    = w_gnt_if;
        dm_gnt    = w_gnt_dm;
        mem_en    = w_gnt_if || w_gnt_dm;
        mem_we    = w_gnt_dm && dm_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_gnt_dm) begin
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (w_gnt_if) begin
            mem_addr  = if_addr;
        end
        stall = (if_req && !w_gnt_if) || (dm_req && !w_gnt_dm);
    end

    // Read sequencing, response capture and the data-run fairness counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_owner     <= OWN_IF;
            r_data_run  <= '0;
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
            if (r_state == IDLE) begin
                if (w_rd_gnt) begin
                    r_cnt   <= LP_LAT;
                    r_owner <= w_gnt_dm ? OWN_DM : OWN_IF;
                end
                if (w_gnt_if || !if_req) begin
                    r_data_run <= '0;
                end else if (w_gnt_dm && (r_data_run != LP_MAX_RUN)) begin
                    r_data_run <= r_data_run + 4'd1;
                end
            end else begin
                r_cnt <= r_cnt - 3'd1;
                if (w_last) begin
                    if (r_owner == OWN_DM) begin
                        r_dm_rdata  <= mem_rdata;
                        r_dm_rvalid <= 1'b1;
                    end else begin
                        r_if_rdata  <= mem_rdata;
                        r_if_rvalid <= 1'b1;
                    end
                end
            end
        end
    end

    assign if_rvalid = r_if_rvalid;
    assign dm_rvalid = r_dm_rvalid;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 has MEM_LAT=1, instance 1 MEM_LAT=3.
// Read responses are queued at grant time and checked by an rvalid monitor.
module tb_mem_port_arbiter;

    logic       clk;
    logic       rst       [2];
    logic       if_req    [2];
    logic [7:0] if_addr   [2];
    logic       if_gnt    [2];
    logic       if_rvalid [2];
    logic [7:0] if_rdata  [2];
    logic       dm_req    [2];
    logic       dm_we     [2];
    logic [7:0] dm_addr   [2];
    logic [7:0] dm_wdata  [2];
    logic       dm_gnt    [2];
    logic       dm_rvalid [2];
    logic [7:0] dm_rdata  [2];
    logic       mem_en    [2];
    logic       mem_we    [2];
    logic [7:0] mem_addr  [2];
    logic [7:0] mem_wdata [2];
    logic [7:0] mem_rdata [2];
    logic       stall     [2];

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1), .MAX_DATA_RUN(4)) dut0 (
        .clk(clk), .reset(rst[0]),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
        .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
        .dm_req(dm_req[0]), .dm_we(dm_we[0]), .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]),
        .dm_gnt(dm_gnt[0]), .dm_rvalid(dm_rvalid[0]), .dm_rdata(dm_rdata[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .stall(stall[0])
    );

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(3), .MAX_DATA_RUN(4)) dut1 (
        .clk(clk), .reset(rst[1]),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
        .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
        .dm_req(dm_req[1]), .dm_we(dm_we[1]), .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]),
        .dm_gnt(dm_gnt[1]), .dm_rvalid(dm_rvalid[1]), .dm_rdata(dm_rdata[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .stall(stall[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: contents addr^0xB5 until written; read data is only
    // presented in the cycle it is due, otherwise 0xEE.
    logic [7:0] mem  [2][256];
    logic [8:0] pipe [2][8];
    always @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (cyc == 0) begin
                for (int a = 0; a < 256; a++) mem[p][a] <= 8'(a) ^ 8'hB5;
            end else if (mem_en[p] && mem_we[p]) begin
                mem[p][mem_addr[p]] <= mem_wdata[p];
            end
            for (int k = 7; k > 0; k--) pipe[p][k] <= pipe[p][k-1];
            pipe[p][0] <= {mem_en[p] && !mem_we[p], mem_addr[p]};
        end
    end
    assign mem_rdata[0] = pipe[0][0][8] ? mem[0][pipe[0][0][7:0]] : 8'hEE;
    assign mem_rdata[1] = pipe[1][2][8] ? mem[1][pipe[1][2][7:0]] : 8'hEE;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard entry ids: 0=if0 1=dm0 2=if1 3=dm1
    typedef struct {
        int         id;
        logic [7:0] d;
        int         c;
    } exp_t;
    exp_t sb[$];

    task automatic push(input int id, input logic [7:0] d, input int lat);
        sb.push_back('{id, d, cyc + lat + 1});
    endtask

    // Monitor: every rvalid pulse must match the oldest expected response
    logic       mon_v;
    logic [7:0] mon_d;
    exp_t       mon_e;
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            mon_v = (k[0] == 1'b0) ? if_rvalid[k/2] : dm_rvalid[k/2];
            mon_d = (k[0] == 1'b0) ? if_rdata[k/2]  : dm_rdata[k/2];
            if (mon_v) begin
                if (sb.size() == 0) begin
                    chk($sformatf("unexpected_rvalid_port%0d", k), 32'(mon_v), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rvalid_port", 32'(k), 32'(mon_e.id));
                    chk("rdata", 32'(mon_d), 32'(mon_e.d));
                    chk("rvalid_cycle", 32'(cyc), 32'(mon_e.c));
                end
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk_zero(input int p);
        chk("rst_if_gnt",    32'(if_gnt[p]),    32'd0);
        chk("rst_dm_gnt",    32'(dm_gnt[p]),    32'd0);
        chk("rst_mem_en",    32'(mem_en[p]),    32'd0);
        chk("rst_mem_we",    32'(mem_we[p]),    32'd0);
        chk("rst_mem_addr",  32'(mem_addr[p]),  32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata[p]), 32'd0);
        chk("rst_if_rvalid", 32'(if_rvalid[p]), 32'd0);
        chk("rst_dm_rvalid", 32'(dm_rvalid[p]), 32'd0);
        chk("rst_if_rdata",  32'(if_rdata[p]),  32'd0);
        chk("rst_dm_rdata",  32'(dm_rdata[p]),  32'd0);
        chk("rst_stall",     32'(stall[p]),     32'd0);
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            rst[p] = 1'b1; if_req[p] = 1'b0; if_addr[p] = '0;
            dm_req[p] = 1'b0; dm_we[p] = 1'b0; dm_addr[p] = '0; dm_wdata[p] = '0;
        end
        smp();
        smp();
        chk_zero(0);
        chk_zero(1);
        nxt();
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        nxt();

        // Single fetch read, MEM_LAT=1
        if_req[0] = 1'b1; if_addr[0] = 8'h10;
        smp();
        chk("t1_if_gnt",   32'(if_gnt[0]),   32'd1);
        chk("t1_mem_en",   32'(mem_en[0]),   32'd1);
        chk("t1_mem_we",   32'(mem_we[0]),   32'd0);
        chk("t1_mem_addr", 32'(mem_addr[0]), 32'h10);
        chk("t1_stall",    32'(stall[0]),    32'd0);
        push(0, 8'hA5, 1);
        nxt();
        if_req[0] = 1'b0;
        smp();
        chk("t1_wait_mem_en", 32'(mem_en[0]), 32'd0);
        nxt();
        nxt();
        smp();
        chk("t1_rdata_hold",  32'(if_rdata[0]),  32'hA5);
        chk("t1_rvalid_once", 32'(if_rvalid[0]), 32'd0);

        // Simultaneous fetch and data read: data first, fetch on dm_rvalid
        nxt();
        if_req[0] = 1'b1; if_addr[0] = 8'h20;
        dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 8'h40;
        smp();
        chk("t2_dm_gnt",   32'(dm_gnt[0]),   32'd1);
        chk("t2_if_gnt",   32'(if_gnt[0]),   32'd0);
        chk("t2_stall",    32'(stall[0]),    32'd1);
        chk("t2_mem_addr", 32'(mem_addr[0]), 32'h40);
        push(1, 8'hF5, 1);
        nxt();
        dm_req[0] = 1'b0;
        smp();
        chk("t2_wait_if_gnt", 32'(if_gnt[0]), 32'd0);
        chk("t2_wait_stall",  32'(stall[0]),  32'd1);
        nxt();
        smp();
        chk("t2_if_gnt2",   32'(if_gnt[0]),    32'd1);
        chk("t2_dm_rvalid", 32'(dm_rvalid[0]), 32'd1);
        chk("t2_mem_addr2", 32'(mem_addr[0]),  32'h20);
        push(0, 8'h95, 1);
        nxt();
        if_req[0] = 1'b0;
        nxt();
        nxt();

        // Data-run limit: four writes while fetch waits, then fetch
        if_req[0] = 1'b1; if_addr[0] = 8'h30;
        dm_req[0] = 1'b1; dm_we[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dm_addr[0]  = 8'h80 + 8'(i);
            dm_wdata[0] = 8'(17 * (i + 1));
            smp();
            chk("t3_dm_gnt",    32'(dm_gnt[0]),    32'd1);
            chk("t3_if_gnt",    32'(if_gnt[0]),    32'd0);
            chk("t3_mem_we",    32'(mem_we[0]),    32'd1);
            chk("t3_mem_addr",  32'(mem_addr[0]),  32'h80 + 32'(i));
            chk("t3_mem_wdata", 32'(mem_wdata[0]), 32'(17 * (i + 1)));
            chk("t3_stall",     32'(stall[0]),     32'd1);
            nxt();
        end
        dm_addr[0] = 8'h84; dm_wdata[0] = 8'h55;
        smp();
        chk("t3_if_gnt5",   32'(if_gnt[0]),   32'd1);
        chk("t3_dm_gnt5",   32'(dm_gnt[0]),   32'd0);
        chk("t3_mem_addr5", 32'(mem_addr[0]), 32'h30);
        push(0, 8'h85, 1);
        nxt();
        if_addr[0] = 8'h31;
        smp();
        chk("t3_rdwait_gnt", 32'(if_gnt[0] | dm_gnt[0]), 32'd0);
        nxt();
        smp();
        chk("t3_run_clear_dm", 32'(dm_gnt[0]),   32'd1);
        chk("t3_run_clear_if", 32'(if_gnt[0]),   32'd0);
        chk("t3_mem_addr6",    32'(mem_addr[0]), 32'h84);
        nxt();
        dm_req[0] = 1'b0; dm_we[0] = 1'b0;
        smp();
        chk("t3_if_gnt6", 32'(if_gnt[0]), 32'd1);
        push(0, 8'h84, 1);
        nxt();
        if_req[0] = 1'b0;
        nxt();
        nxt();

        // Back-to-back writes without fetch, then read one back
        dm_req[0] = 1'b1; dm_we[0] = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            dm_addr[0]  = 8'(i);
            dm_wdata[0] = 8'hC0 + 8'(i);
            smp();
            chk("t4_dm_gnt",    32'(dm_gnt[0]),    32'd1);
            chk("t4_mem_we",    32'(mem_we[0]),    32'd1);
            chk("t4_mem_addr",  32'(mem_addr[0]),  32'(i));
            chk("t4_mem_wdata", 32'(mem_wdata[0]), 32'hC0 + 32'(i));
            chk("t4_stall",     32'(stall[0]),     32'd0);
            nxt();
        end
        dm_we[0] = 1'b0; dm_addr[0] = 8'h02;
        smp();
        chk("t4_rd_gnt", 32'(dm_gnt[0]), 32'd1);
        push(1, 8'hC2, 1);
        nxt();
        dm_req[0] = 1'b0;
        nxt();
        nxt();

        // MEM_LAT=3: reset one cycle after a fetch grant discards the read
        if_req[1] = 1'b1; if_addr[1] = 8'h50;
        smp();
        chk("t5_if_gnt", 32'(if_gnt[1]), 32'd1);
        nxt();
        if_req[1] = 1'b0;
        rst[1] = 1'b1;
        smp();
        chk_zero(1);
        nxt();
        rst[1] = 1'b0;
        repeat (6) nxt();
        if_req[1] = 1'b1; if_addr[1] = 8'h60;
        smp();
        chk("t5_fresh_gnt", 32'(if_gnt[1]), 32'd1);
        push(2, 8'hD5, 3);
        nxt();
        if_req[1] = 1'b0;
        repeat (5) nxt();

        // MEM_LAT=3: back-to-back fetch reads, grants 4 cycles apart
        if_req[1] = 1'b1; if_addr[1] = 8'h61;
        smp();
        chk("t6_gnt1", 32'(if_gnt[1]), 32'd1);
        push(2, 8'hD4, 3);
        nxt();
        if_addr[1] = 8'h62;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("t6_no_gnt", 32'(if_gnt[1]), 32'd0);
            chk("t6_stall",  32'(stall[1]),  32'd1);
            nxt();
        end
        smp();
        chk("t6_gnt2",      32'(if_gnt[1]),    32'd1);
        chk("t6_gnt2_rval", 32'(if_rvalid[1]), 32'd1);
        push(2, 8'hD7, 3);
        nxt();
        if_req[1] = 1'b0;
        repeat (6) nxt();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
